// File: rtl/nubus_pkg.sv
// Shared definitions for the NuBus memory arbiter: FSM state encoding,
// requester index constants, grant codes and the timeout counter sizing.
package nubus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GNT_A,
    ST_GNT_B,
    ST_DONE
  } state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_t;

  localparam logic [1:0]  GRANT_NONE    = 2'b00;
  localparam logic [1:0]  GRANT_A       = 2'b01;
  localparam logic [1:0]  GRANT_B       = 2'b10;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

  // Counter is at least 8 bits, wider when the timeout value needs it.
  function automatic int unsigned timeout_cnt_width(input int unsigned t);
    int unsigned w;
    w = $clog2(t + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/nubus_mem_arbiter.sv
// Two-requester arbiter (A = NuBus slave side, B = local master) in front of a
// single shared memory port. Registered arbitration, one-cycle DONE gap after
// every completion, optional wait-state timeout that completes with an error.
module nubus_mem_arbiter
  import nubus_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned FIXED_PRIO   = 0
) (
  input  logic        mem_clk,
  input  logic        mem_reset,
  input  logic        a_valid,
  input  logic [3:0]  a_wstrb,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic [31:0] a_rdata,
  output logic        a_ready,
  output logic        a_error,
  input  logic        b_valid,
  input  logic [3:0]  b_wstrb,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic [31:0] b_rdata,
  output logic        b_ready,
  output logic        b_error,
  output logic        m_valid,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic [1:0]  grant,
  output logic        busy
);

  localparam int unsigned       CNT_W        = timeout_cnt_width(WAIT_TIMEOUT);
  localparam bit                TIMEOUT_EN   = (WAIT_TIMEOUT != 0);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_EN ? WAIT_TIMEOUT - 1 : 0);

  state_t           state, state_next;
  port_t            last_grant, last_next;
  logic [CNT_W-1:0] wait_cnt, wait_next;

  logic        in_grant;
  logic        sel_b;
  logic        x_valid;
  logic        hit_ready;
  logic        hit_timeout;
  logic        complete;
  logic [31:0] x_rdata;

  // Both grant states share one completion path; sel_b picks the owner.
  assign in_grant    = (state == ST_GNT_A) || (state == ST_GNT_B);
  assign sel_b       = (state == ST_GNT_B);
  assign x_valid     = sel_b ? b_valid : a_valid;
  assign hit_ready   = in_grant && x_valid && m_ready;
  assign hit_timeout = in_grant && x_valid && !m_ready && TIMEOUT_EN &&
                       (wait_cnt == TIMEOUT_LAST);
  assign complete    = hit_ready || hit_timeout;
  assign x_rdata     = hit_timeout ? TIMEOUT_RDATA : m_rdata;
  assign busy        = (grant != GRANT_NONE);

  // State, round-robin pointer and wait counter registers.
  always_ff @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset) begin
      state      <= ST_IDLE;
      last_grant <= PORT_B;
      wait_cnt   <= '0;
    end else begin
      state      <= state_next;
      last_grant <= last_next;
      wait_cnt   <= wait_next;
    end
  end

  // Next-state: arbitration in IDLE, completion/abort/timeout while granted.
  always_comb begin
    state_next = state;
    last_next  = last_grant;
    wait_next  = wait_cnt;
    case (state)
      ST_IDLE: begin
        wait_next = '0;
        if (a_valid && (!b_valid || FIXED_PRIO != 0 || last_grant == PORT_B)) begin
          state_next = ST_GNT_A;
          last_next  = PORT_A;
        end else if (b_valid) begin
          state_next = ST_GNT_B;
          last_next  = PORT_B;
        end
      end
      ST_GNT_A, ST_GNT_B: begin
        if (!x_valid) begin
          state_next = ST_IDLE;
        end else if (complete) begin
          state_next = ST_DONE;
        end else if (TIMEOUT_EN) begin
          wait_next = wait_cnt + CNT_W'(1);
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output routing: granted port drives the memory side, completions go back.
  always_comb begin
    m_valid = 1'b0;
    m_wstrb = '0;
    m_addr  = '0;
    m_wdata = '0;
    a_rdata = '0;
    a_ready = 1'b0;
    a_error = 1'b0;
    b_rdata = '0;
    b_ready = 1'b0;
    b_error = 1'b0;
    grant   = GRANT_NONE;
    if (in_grant) begin
      grant   = sel_b ? GRANT_B : GRANT_A;
      m_valid = x_valid;
      m_wstrb = sel_b ? b_wstrb : a_wstrb;
      m_addr  = sel_b ? b_addr  : a_addr;
      m_wdata = sel_b ? b_wdata : a_wdata;
      if (complete) begin
        if (sel_b) begin
          b_ready = 1'b1;
          b_error = hit_timeout;
          b_rdata = x_rdata;
        end else begin
          a_ready = 1'b1;
          a_error = hit_timeout;
          a_rdata = x_rdata;
        end
      end
    end
  end

endmodule

// File: doc/nubus_mem_arbiter.md
NUBUS_MEM_ARBITER -- requirements
Module: nubus_mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_TIMEOUT, default 255, meaning grant cycles without m_ready before forced error completion (0 = timeout disabled).
REQ-002 SHALL have parameter FIXED_PRIO, default 0, meaning 1 = port A always wins, 0 = round-robin.
REQ-003 SHALL have port mem_clk  in  1  clock; all logic rising-edge.
REQ-004 SHALL have port mem_reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports a_valid in 1, a_wstrb in 4, a_addr in 32, a_wdata in 32: requester A (NuBus slave side) request; held until a_ready.
REQ-006 SHALL have ports a_rdata out 32, a_ready out 1, a_error out 1: requester A completion.
REQ-007 SHALL have ports b_valid, b_wstrb, b_addr, b_wdata, b_rdata, b_ready, b_error: requester B (local master), identical widths and meanings to A.
REQ-008 SHALL have ports m_valid out 1, m_wstrb out 4, m_addr out 32, m_wdata out 32: shared memory request.
REQ-009 SHALL have ports m_rdata in 32, m_ready in 1: shared memory response; m_rdata lanes may be Z on written bytes.
REQ-010 SHALL have ports grant out 2 (one-hot {B,A}, 00 = none) and busy out 1 (grant != 00).

Function
REQ-011 SHALL implement FSM states IDLE, GNT_A, GNT_B, DONE.
REQ-012 IDLE: a_valid only -> GNT_A; b_valid only -> GNT_B; both -> FIXED_PRIO ? GNT_A : port not granted last; neither -> stay.
REQ-013 Arbitration SHALL be registered: one-cycle latency from valid to m_valid.
REQ-014 In GNT_x: m_valid = x_valid; m_wstrb/m_addr/m_wdata = port x signals combinationally; ungranted port fields forced 0 on memory side.
REQ-015 In GNT_x with m_ready=1: x_ready=1 and x_rdata=m_rdata same cycle; next state DONE.
REQ-016 DONE: m_valid=0 for exactly one cycle, then IDLE; guarantees requester deasserts valid before re-arbitration.
REQ-017 In GNT_x with x_valid=0 (requester abort): next state IDLE, no x_ready, m_valid=0 that cycle.
REQ-018 Timeout counter (8-bit min, width from WAIT_TIMEOUT) SHALL clear on grant entry, increment each GNT cycle without m_ready.
REQ-019 Counter == WAIT_TIMEOUT-1 without m_ready: x_ready=1, x_error=1, x_rdata=32'hFFFFFFFF one cycle; next DONE.
REQ-020 m_ready and timeout in same cycle: m_ready wins, x_error=0.
REQ-021 Ungranted port: x_ready=0, x_error=0, x_rdata=0 always.
REQ-022 Round-robin pointer (last_grant) SHALL update only on GNT entry.
REQ-023 m_ready in IDLE or DONE SHALL be ignored.

Reset
REQ-024 mem_reset SHALL force state IDLE, last_grant=B (A wins first tie), counter 0, all outputs 0, mid-transaction included; no completion issued for aborted access.

Structure
REQ-025 State encoding and port index constants SHALL live in shared package nubus_pkg.
REQ-026 Single module, no sub-modules; timeout counter inline.

Verification
REQ-027 a_valid write addr 0x10 data 0xDEADBEEF wstrb 1111, memory WAIT_CLOCKS=2 -> m_valid cycle 1, a_ready cycle 3, grant=01, readback 0xDEADBEEF.
REQ-028 a_valid and b_valid same cycle, FIXED_PRIO=0, both repeat 4 times -> grants alternate A,B,A,B,... with one DONE gap each.
REQ-029 FIXED_PRIO=1, both continuously valid -> B never granted; b_ready stays 0.
REQ-030 WAIT_TIMEOUT=4, m_ready tied 0 -> b_ready=b_error=1, b_rdata=0xFFFFFFFF on 4th grant cycle.
REQ-031 mem_reset pulsed during GNT_A -> next edge grant=00, m_valid=0, no a_ready.
REQ-032 b_valid dropped after 1 grant cycle -> IDLE, no b_ready, pending a_valid granted next cycle.
